// File: rtl/pulse_stretch_pkg.sv
// Shared types and default timing for the pulse stretcher.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  // 1 ms on / 1 ms gap at a 100 MHz clock
  localparam int DEFAULT_ON_CYCLES  = 100000;
  localparam int DEFAULT_GAP_CYCLES = 100000;
  localparam int DEFAULT_CNT_W      = 20;
  localparam int DEFAULT_PEND_W     = 4;

endpackage

// File: rtl/pulse_stretch_sat_counter.sv
// Up/down event counter that saturates at its maximum and never underflows.
module pulse_stretch_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_drop
);

  logic [W-1:0] r_count;
  logic         w_full;

  assign w_full  = (r_count == {W{1'b1}});
  // Simultaneous inc and dec cancel, so a full counter only drops an unpaired inc
  assign o_drop  = i_inc && !i_dec && w_full;
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && !w_full) begin
      r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle event strobes into fixed on-time blinks with a queue.
// Define PULSE_STRETCH_ACTIVE_LOW_EN to drive led_out active-low.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int ON_CYCLES  = DEFAULT_ON_CYCLES,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
  parameter int CNT_W      = DEFAULT_CNT_W,
  parameter int PEND_W     = DEFAULT_PEND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

`ifdef PULSE_STRETCH_ACTIVE_LOW_EN
  localparam logic LED_ON = 1'b0;
`else
  localparam logic LED_ON = 1'b1;
`endif

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [PEND_W-1:0]  w_pending;
  logic               w_have_pend, w_start, w_inc, w_dec, w_drop;
  logic               w_on_last, w_gap_last;
  logic               r_led, r_busy, r_overflow;

  assign w_have_pend = (w_pending != '0);
  assign w_on_last   = (r_cnt == CNT_W'(ON_CYCLES - 1));
  assign w_gap_last  = (r_cnt == CNT_W'(GAP_CYCLES - 1));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_start      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (pulse_in || w_have_pend) begin
          w_state_next = ON;
          w_start      = 1'b1;
        end
      end
      ON: begin
        if (w_on_last) begin
          w_state_next = GAP;
          w_cnt_next   = '0;
        end
      end
      GAP: begin
        if (w_gap_last) begin
          w_cnt_next = '0;
          if (pulse_in || w_have_pend) begin
            w_state_next = ON;
            w_start      = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // A starting blink takes the oldest queued event; pulse_in is queued unless it is the one consumed
  assign w_dec = w_start && w_have_pend;
  assign w_inc = pulse_in && !(w_start && !w_have_pend);

  pulse_stretch_sat_counter #(
    .W (PEND_W)
  ) u_pend (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .o_count (w_pending),
    .o_drop  (w_drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_led      <= ~LED_ON;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_led      <= (w_state_next == ON) ? LED_ON : ~LED_ON;
      r_busy     <= (w_state_next != IDLE);
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign led_out  = r_led;
  assign busy     = r_busy;
  assign pending  = w_pending;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_pulse_stretch.sv
// Scoreboard bench for pulse_stretch (ON=4, GAP=3, PEND_W=2); per-cycle expectations from hand-written strings.
module tb_pulse_stretch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulse_in = 1'b0;
  logic       led_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string name;
    int    cyc;
    byte   led;
    byte   bsy;
    byte   pnd;
    byte   ovf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pulse_stretch #(
    .ON_CYCLES  (4),
    .GAP_CYCLES (3),
    .CNT_W      (3),
    .PEND_W     (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .led_out  (led_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  function automatic string rep(byte c, int n);
    string s;
    string one;
    s = "";
    one = " ";
    one[0] = c;
    for (int i = 0; i < n; i++) s = {s, one};
    return s;
  endfunction

  function automatic logic exp_led(byte c);
`ifdef PULSE_STRETCH_ACTIVE_LOW_EN
    return (c != 8'h31);
`else
    return (c == 8'h31);
`endif
  endfunction

  // Monitor: one expectation per cycle, compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] ep;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.led != 8'h78) begin
        n_checks++;
        if (led_out !== exp_led(e.led)) begin
          n_fail++;
          $display("FAIL %s led cyc=%0d got=%b exp=%b", e.name, e.cyc, led_out, exp_led(e.led));
        end
      end
      if (e.bsy != 8'h78) begin
        n_checks++;
        if (busy !== (e.bsy == 8'h31)) begin
          n_fail++;
          $display("FAIL %s busy cyc=%0d got=%b exp=%b", e.name, e.cyc, busy, (e.bsy == 8'h31));
        end
      end
      if (e.pnd != 8'h78) begin
        ep = 2'(e.pnd - 8'h30);
        n_checks++;
        if (pending !== ep) begin
          n_fail++;
          $display("FAIL %s pending cyc=%0d got=%0d exp=%0d", e.name, e.cyc, pending, ep);
        end
      end
      if (e.ovf != 8'h78) begin
        n_checks++;
        if (overflow !== (e.ovf == 8'h31)) begin
          n_fail++;
          $display("FAIL %s overflow cyc=%0d got=%b exp=%b", e.name, e.cyc, overflow, (e.ovf == 8'h31));
        end
      end
      $display("%s cyc=%0d rst=%b pulse=%b led=%b busy=%b pending=%0d ovf=%b",
               e.name, e.cyc, rst, pulse_in, led_out, busy, pending, overflow);
    end
  end

  task automatic run(input string name, input string r, input string p, input string l,
                     input string b, input string pd, input string o);
    int n;
    n = r.len();
    n_checks++;
    if (p.len() != n || l.len() != n || b.len() != n || pd.len() != n || o.len() != n) begin
      n_fail++;
      $display("FAIL %s vector_len got=%0d/%0d/%0d/%0d/%0d exp=%0d",
               name, p.len(), l.len(), b.len(), pd.len(), o.len(), n);
      return;
    end
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      rst      = (r[k] == 8'h31);
      pulse_in = (p[k] == 8'h31);
      sb.push_back('{name, k, l[k], b[k], pd[k], o[k]});
    end
  endtask

  initial begin
    // single pulse at cycle 10
    run("single",
        {rep("1",1), rep("0",21)},
        {rep("0",10), rep("1",1), rep("0",11)},
        {rep("x",1), rep("0",10), rep("1",4), rep("0",7)},
        {rep("x",1), rep("0",10), rep("1",7), rep("0",4)},
        {rep("x",1), rep("0",21)},
        {rep("x",1), rep("0",21)});

    // pulses at 10, 12, 13: three blinks
    run("queue",
        {rep("1",1), rep("0",33)},
        {rep("0",10), rep("1",1), rep("0",1), rep("1",2), rep("0",20)},
        {rep("x",1), rep("0",10), rep("1",4), rep("0",3), rep("1",4), rep("0",3), rep("1",4), rep("0",5)},
        {rep("x",1), rep("0",10), rep("1",21), rep("0",2)},
        {rep("x",1), rep("0",12), rep("1",1), rep("2",4), rep("1",7), rep("0",9)},
        {rep("x",1), rep("0",33)});

    // pulse held 10..14: saturation, one dropped, four blinks
    run("saturate",
        {rep("1",1), rep("0",40)},
        {rep("0",10), rep("1",5), rep("0",26)},
        {rep("x",1), rep("0",10), rep("1",4), rep("0",3), rep("1",4), rep("0",3),
         rep("1",4), rep("0",3), rep("1",4), rep("0",5)},
        {rep("x",1), rep("0",10), rep("1",28), rep("0",2)},
        {rep("x",1), rep("0",11), rep("1",1), rep("2",1), rep("3",4), rep("2",7), rep("1",7), rep("0",9)},
        {rep("x",1), rep("0",14), rep("1",26)});

    // pulse on the last GAP cycle: back-to-back blink, no IDLE cycle
    run("gap_last",
        {rep("1",1), rep("0",29)},
        {rep("0",10), rep("1",1), rep("0",6), rep("1",1), rep("0",12)},
        {rep("x",1), rep("0",10), rep("1",4), rep("0",3), rep("1",4), rep("0",8)},
        {rep("x",1), rep("0",10), rep("1",14), rep("0",5)},
        {rep("x",1), rep("0",29)},
        {rep("x",1), rep("0",29)});

    // reset mid-blink with pending=2, then a fresh pulse
    run("reset_mid",
        {rep("1",1), rep("0",12), rep("1",1), rep("0",16)},
        {rep("0",10), rep("1",3), rep("0",7), rep("1",1), rep("0",9)},
        {rep("x",1), rep("0",10), rep("1",3), rep("0",7), rep("1",4), rep("0",5)},
        {rep("x",1), rep("0",10), rep("1",3), rep("0",7), rep("1",7), rep("0",2)},
        {rep("x",1), rep("0",11), rep("1",1), rep("2",1), rep("0",16)},
        {rep("x",1), rep("0",29)});

    repeat (2) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
